// File: rtl/nf2_reg_router_if.sv
// CPU register bus bundle: CPCI request FIFO / return side plus the shared target register bus.
// master is the router's view, slave the view of the FIFO and target blocks.
interface nf2_reg_router_if #(
    parameter int NUM_TARGETS    = 4,
    parameter int ADDR_WIDTH     = 27,
    parameter int DATA_WIDTH     = 32,
    parameter int TGT_ADDR_WIDTH = 16
);
    logic                              fifo_empty;
    logic                              fifo_rd_en;
    logic                              bus_rd_wr_L;
    logic [ADDR_WIDTH-1:0]             bus_addr;
    logic [DATA_WIDTH-1:0]             bus_wr_data;
    logic [DATA_WIDTH-1:0]             bus_rd_data;
    logic                              bus_rd_vld;
    logic [NUM_TARGETS-1:0]            tgt_reg_req;
    logic                              tgt_reg_rd_wr_L;
    logic [TGT_ADDR_WIDTH-1:0]         tgt_reg_addr;
    logic [DATA_WIDTH-1:0]             tgt_reg_wr_data;
    logic [NUM_TARGETS-1:0]            tgt_reg_ack;
    logic [NUM_TARGETS*DATA_WIDTH-1:0] tgt_reg_rd_data;
    logic                              err_timeout;

    modport master (
        input  fifo_empty, bus_rd_wr_L, bus_addr, bus_wr_data, tgt_reg_ack, tgt_reg_rd_data,
        output fifo_rd_en, bus_rd_data, bus_rd_vld, tgt_reg_req, tgt_reg_rd_wr_L,
               tgt_reg_addr, tgt_reg_wr_data, err_timeout
    );

    modport slave (
        output fifo_empty, bus_rd_wr_L, bus_addr, bus_wr_data, tgt_reg_ack, tgt_reg_rd_data,
        input  fifo_rd_en, bus_rd_data, bus_rd_vld, tgt_reg_req, tgt_reg_rd_wr_L,
               tgt_reg_addr, tgt_reg_wr_data, err_timeout
    );
endinterface

// File: rtl/nf2_reg_router.sv
// N-target CPU register router: pops one CPCI request, decodes the tag against TARGET_BASE,
// drives a one-hot target request and returns data or 0xDEADBEEF. Option: NF2_REG_ROUTER_STATS_EN.
module nf2_reg_router #(
    parameter int NUM_TARGETS    = 4,
    parameter int ADDR_WIDTH     = 27,
    parameter int DATA_WIDTH     = 32,
    parameter int TGT_ADDR_WIDTH = 16,
    parameter logic [NUM_TARGETS*(ADDR_WIDTH-2-TGT_ADDR_WIDTH)-1:0] TARGET_BASE =
        {9'h030, 9'h020, 9'h010, 9'h000},
    parameter int TIMEOUT        = 511
) (
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef NF2_REG_ROUTER_STATS_EN
    output logic [15:0]           stat_timeout_cnt,
    output logic [ADDR_WIDTH-3:0] stat_last_err_addr,
`endif
    nf2_reg_router_if.master      bus
);
    localparam int WADDR_W = ADDR_WIDTH - 2;
    localparam int TAG_W   = WADDR_W - TGT_ADDR_WIDTH;
    localparam int SEL_W   = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int CNT_W   = ($clog2(TIMEOUT + 1) < 9) ? 9 : $clog2(TIMEOUT + 1);
    localparam logic [DATA_WIDTH-1:0] BAD_DATA = DATA_WIDTH'(32'hDEADBEEF);

    typedef enum logic [1:0] {IDLE, GET_REQ, WAIT_ACK, DONE} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SEL_W-1:0]       sel;
    logic                   hit_q;
    logic                   rd_q;

    logic [WADDR_W-1:0]     waddr;
    logic [TAG_W-1:0]       tag;
    logic [NUM_TARGETS-1:0] match;
    logic                   hit;
    logic [SEL_W-1:0]       hit_idx;
    logic [NUM_TARGETS-1:0] onehot;
    logic                   ack_sel;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   unused_byte_bits;

    // Byte-lane bits are dropped: targets are word addressed.
    assign unused_byte_bits = ^bus.bus_addr[1:0];
    assign waddr = bus.bus_addr[ADDR_WIDTH-1:2];
    assign tag   = waddr[WADDR_W-1:TGT_ADDR_WIDTH];

    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_tag
        assign match[gi] = (tag == TARGET_BASE[gi*TAG_W +: TAG_W]);
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = |match;
        hit_idx = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = SEL_W'(i);
        end
    end

    assign onehot   = hit ? (NUM_TARGETS'(1) << hit_idx) : '0;
    assign ack_sel  = bus.tgt_reg_ack[sel];
    assign sel_data = bus.tgt_reg_rd_data[sel*DATA_WIDTH +: DATA_WIDTH];

    assign bus.fifo_rd_en = (state == IDLE) && !bus.fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            sel                 <= '0;
            hit_q               <= 1'b0;
            rd_q                <= 1'b0;
            bus.bus_rd_data     <= '0;
            bus.bus_rd_vld      <= 1'b0;
            bus.tgt_reg_req     <= '0;
            bus.tgt_reg_rd_wr_L <= 1'b1;
            bus.tgt_reg_addr    <= '0;
            bus.tgt_reg_wr_data <= '0;
            bus.err_timeout     <= 1'b0;
        end else begin
            bus.bus_rd_vld  <= 1'b0;
            bus.err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.fifo_empty) state <= GET_REQ;
                end
                GET_REQ: begin
                    rd_q                <= bus.bus_rd_wr_L;
                    hit_q               <= hit;
                    sel                 <= hit_idx;
                    cnt                 <= CNT_W'(TIMEOUT);
                    bus.tgt_reg_req     <= onehot;
                    bus.tgt_reg_rd_wr_L <= bus.bus_rd_wr_L;
                    bus.tgt_reg_addr    <= waddr[TGT_ADDR_WIDTH-1:0];
                    bus.tgt_reg_wr_data <= bus.bus_rd_wr_L ? '0 : bus.bus_wr_data;
                    state               <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Ack is checked ahead of expiry so a last-cycle ack still returns real data.
                    if (!hit_q || ack_sel || cnt == '0) begin
                        state               <= DONE;
                        bus.tgt_reg_req     <= '0;
                        bus.tgt_reg_rd_wr_L <= 1'b1;
                        bus.bus_rd_vld      <= rd_q;
                        bus.err_timeout     <= hit_q && !ack_sel;
                        if (rd_q) bus.bus_rd_data <= (hit_q && ack_sel) ? sel_data : BAD_DATA;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NF2_REG_ROUTER_STATS_EN
    logic [WADDR_W-1:0] waddr_q;
    logic               to_evt;
    logic               unmap_evt;

    assign to_evt    = (state == WAIT_ACK) && hit_q && !ack_sel && (cnt == '0);
    assign unmap_evt = (state == WAIT_ACK) && !hit_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waddr_q            <= '0;
            stat_timeout_cnt   <= '0;
            stat_last_err_addr <= '0;
        end else begin
            if (state == GET_REQ) waddr_q <= waddr;
            if (to_evt && stat_timeout_cnt != 16'hFFFF) stat_timeout_cnt <= stat_timeout_cnt + 16'd1;
            if (to_evt || unmap_evt) stat_last_err_addr <= waddr_q;
        end
    end
`endif

endmodule

// File: tb/tb_nf2_reg_router.sv
// Directed bench for nf2_reg_router: reads, writes, unmapped, timeout, foreign ack, reset.
module tb_nf2_reg_router;
    localparam int TIMEOUT = 511;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   vld_cnt = 0;
    int   vld_mark;

    always #5 clk = ~clk;

    nf2_reg_router_if #(.NUM_TARGETS(4), .ADDR_WIDTH(27), .DATA_WIDTH(32), .TGT_ADDR_WIDTH(16)) bus ();

`ifdef NF2_REG_ROUTER_STATS_EN
    logic [15:0] stat_timeout_cnt;
    logic [24:0] stat_last_err_addr;
`endif

    nf2_reg_router #(.TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
`ifdef NF2_REG_ROUTER_STATS_EN
        .stat_timeout_cnt   (stat_timeout_cnt),
        .stat_last_err_addr (stat_last_err_addr),
`endif
        .bus                (bus.master)
    );

    // Counts completed return strobes (value seen before the edge updates it).
    always @(posedge clk) if (bus.bus_rd_vld) vld_cnt++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one FIFO entry, check the pop, and return at the GET_REQ cycle.
    task automatic issue(input logic rd, input logic [26:0] a, input logic [31:0] d);
        bus.bus_rd_wr_L = rd;
        bus.bus_addr    = a;
        bus.bus_wr_data = d;
        bus.fifo_empty  = 1'b0;
        #1 chk("pop_strobe", {63'd0, bus.fifo_rd_en}, 64'd1);
        tick();
        bus.fifo_empty = 1'b1;
    endtask

    initial begin
        bus.fifo_empty      = 1'b1;
        bus.bus_rd_wr_L     = 1'b1;
        bus.bus_addr        = '0;
        bus.bus_wr_data     = '0;
        bus.tgt_reg_ack     = '0;
        bus.tgt_reg_rd_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        tick(); tick();

        // Reset values
        chk("rst_req",     bus.tgt_reg_req, 0);
        chk("rst_rdwrL",   bus.tgt_reg_rd_wr_L, 1);
        chk("rst_vld",     bus.bus_rd_vld, 0);
        chk("rst_rdata",   bus.bus_rd_data, 0);
        chk("rst_err",     bus.err_timeout, 0);
        chk("rst_pop",     bus.fifo_rd_en, 0);
        chk("rst_taddr",   bus.tgt_reg_addr, 0);
        chk("rst_twdata",  bus.tgt_reg_wr_data, 0);
`ifdef NF2_REG_ROUTER_STATS_EN
        chk("rst_stat_to",  stat_timeout_cnt, 0);
        chk("rst_stat_adr", stat_last_err_addr, 0);
`endif
        reset_n = 1'b1;
        tick();

        // 1: read 0x0400000 -> target 1, ack after 3 cycles
        issue(1'b1, 27'h0400000, 32'h0);
        chk("t1_pop_low", bus.fifo_rd_en, 0);
        tick();
        chk("t1_req",    bus.tgt_reg_req, 4'b0010);
        chk("t1_taddr",  bus.tgt_reg_addr, 16'h0000);
        chk("t1_rdwrL",  bus.tgt_reg_rd_wr_L, 1);
        chk("t1_twdata", bus.tgt_reg_wr_data, 0);
        tick(); tick();
        chk("t1_req_hold", bus.tgt_reg_req, 4'b0010);
        chk("t1_no_vld",   bus.bus_rd_vld, 0);
        bus.tgt_reg_rd_data[32 +: 32] = 32'h12345678;
        bus.tgt_reg_ack = 4'b0010;
        tick();
        bus.tgt_reg_ack = 4'b0000;
        chk("t1_vld",   bus.bus_rd_vld, 1);
        chk("t1_rdata", bus.bus_rd_data, 32'h12345678);
        chk("t1_req0",  bus.tgt_reg_req, 0);
        chk("t1_err",   bus.err_timeout, 0);
        tick();
        chk("t1_vld_pulse", bus.bus_rd_vld, 0);

        // 2: write 0xA5A5A5A5 to target 0 (word address 4)
        vld_mark = vld_cnt;
        issue(1'b0, 27'h0000010, 32'hA5A5A5A5);
        tick();
        chk("t2_req",    bus.tgt_reg_req, 4'b0001);
        chk("t2_twdata", bus.tgt_reg_wr_data, 32'hA5A5A5A5);
        chk("t2_rdwrL",  bus.tgt_reg_rd_wr_L, 0);
        chk("t2_taddr",  bus.tgt_reg_addr, 16'h0004);
        bus.tgt_reg_ack = 4'b0001;
        tick();
        bus.tgt_reg_ack = 4'b0000;
        chk("t2_req0",   bus.tgt_reg_req, 0);
        chk("t2_rdwrL1", bus.tgt_reg_rd_wr_L, 1);
        chk("t2_err",    bus.err_timeout, 0);
        tick(); tick();
        chk("t2_no_vld", vld_cnt - vld_mark, 0);

        // 3: unmapped tag 0x1FF
        issue(1'b1, 27'h7FC0000, 32'h0);
        tick();
        chk("t3_req", bus.tgt_reg_req, 0);
        chk("t3_vld_early", bus.bus_rd_vld, 0);
        tick();
        chk("t3_vld",   bus.bus_rd_vld, 1);
        chk("t3_rdata", bus.bus_rd_data, 32'hDEADBEEF);
        chk("t3_err",   bus.err_timeout, 0);
`ifdef NF2_REG_ROUTER_STATS_EN
        tick();
        chk("t3_stat_adr", stat_last_err_addr, 25'h1FF0000);
        chk("t3_stat_to",  stat_timeout_cnt, 0);
`endif
        tick();

        // 4: target 2 never acks -> req held TIMEOUT+1 cycles
        issue(1'b1, 27'h0800000, 32'h0);
        tick();
        chk("t4_req", bus.tgt_reg_req, 4'b0100);
        repeat (TIMEOUT) tick();
        chk("t4_req_last", bus.tgt_reg_req, 4'b0100);
        chk("t4_no_vld",   bus.bus_rd_vld, 0);
        tick();
        chk("t4_req0",  bus.tgt_reg_req, 0);
        chk("t4_vld",   bus.bus_rd_vld, 1);
        chk("t4_rdata", bus.bus_rd_data, 32'hDEADBEEF);
        chk("t4_err",   bus.err_timeout, 1);
        tick();
        chk("t4_err_pulse", bus.err_timeout, 0);
`ifdef NF2_REG_ROUTER_STATS_EN
        chk("t4_stat_to",  stat_timeout_cnt, 1);
        chk("t4_stat_adr", stat_last_err_addr, 25'h0200000);
`endif
        tick();

        // 4b: target 3 acks in the final counter cycle -> ack wins
        issue(1'b1, 27'h0C00000, 32'h0);
        tick();
        repeat (TIMEOUT) tick();
        chk("t4b_req_last", bus.tgt_reg_req, 4'b1000);
        bus.tgt_reg_rd_data[96 +: 32] = 32'hCAFEF00D;
        bus.tgt_reg_ack = 4'b1000;
        tick();
        bus.tgt_reg_ack = 4'b0000;
        chk("t4b_vld",   bus.bus_rd_vld, 1);
        chk("t4b_rdata", bus.bus_rd_data, 32'hCAFEF00D);
        chk("t4b_err",   bus.err_timeout, 0);
        tick(); tick();

        // 5: foreign ack on target 2 while target 0 selected
        issue(1'b1, 27'h0000020, 32'h0);
        tick();
        chk("t5_req", bus.tgt_reg_req, 4'b0001);
        bus.tgt_reg_rd_data[64 +: 32] = 32'hBAD0BAD0;
        bus.tgt_reg_ack = 4'b0100;
        tick(); tick();
        chk("t5_req_hold", bus.tgt_reg_req, 4'b0001);
        chk("t5_no_vld",   bus.bus_rd_vld, 0);
        bus.tgt_reg_rd_data[0 +: 32] = 32'h0000AAAA;
        bus.tgt_reg_ack = 4'b0001;
        tick();
        bus.tgt_reg_ack = 4'b0000;
        chk("t5_vld",   bus.bus_rd_vld, 1);
        chk("t5_rdata", bus.bus_rd_data, 32'h0000AAAA);
        tick(); tick();

        // 6: back-to-back entries, then reset during the second WAIT_ACK
        bus.bus_rd_wr_L = 1'b1;
        bus.bus_addr    = 27'h0400004;
        bus.fifo_empty  = 1'b0;
        #1 chk("t6_pop1", bus.fifo_rd_en, 1);
        tick();
        tick();
        chk("t6_req1",   bus.tgt_reg_req, 4'b0010);
        chk("t6_taddr1", bus.tgt_reg_addr, 16'h0001);
        bus.tgt_reg_rd_data[32 +: 32] = 32'h11111111;
        bus.tgt_reg_ack = 4'b0010;
        tick();
        bus.tgt_reg_ack = 4'b0000;
        chk("t6_rdata1", bus.bus_rd_data, 32'h11111111);
        bus.bus_addr = 27'h0000008;
        tick();
        chk("t6_pop2", bus.fifo_rd_en, 1);
        tick();
        bus.fifo_empty = 1'b1;
        tick();
        chk("t6_req2", bus.tgt_reg_req, 4'b0001);
        vld_mark = vld_cnt;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_req",   bus.tgt_reg_req, 0);
        chk("t6_rst_rdwrL", bus.tgt_reg_rd_wr_L, 1);
        chk("t6_rst_rdata", bus.bus_rd_data, 0);
        chk("t6_rst_taddr", bus.tgt_reg_addr, 0);
        bus.tgt_reg_ack = 4'b0001;
        tick(); tick();
        bus.tgt_reg_ack = 4'b0000;
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("t6_no_resp", vld_cnt - vld_mark, 0);
        chk("t6_idle_req", bus.tgt_reg_req, 0);

        // Recovery after reset: plain read of target 3
        issue(1'b1, 27'h0C00010, 32'h0);
        tick();
        chk("t7_req", bus.tgt_reg_req, 4'b1000);
        bus.tgt_reg_rd_data[96 +: 32] = 32'h5A5A0001;
        bus.tgt_reg_ack = 4'b1000;
        tick();
        bus.tgt_reg_ack = 4'b0000;
        chk("t7_rdata", bus.bus_rd_data, 32'h5A5A0001);
        chk("t7_vld",   bus.bus_rd_vld, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
